// File: rtl/alu_issue_stage.sv
// Execute-stage issue front end: decodes ALUOp/funct into the ALU op code and buffers ops in a 2-entry skid FIFO.
// Optional statistics counters (issue_cnt, illegal_cnt) are built only when ISSUE_CNT_EN is defined.
module alu_issue_stage #(
    parameter int N     = 32,
    parameter int CNT_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_aluop,
    input  logic [5:0]   in_funct,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   out_op,
    output logic [N-1:0] out_a,
    output logic [N-1:0] out_b,
    output logic         out_illegal
`ifdef ISSUE_CNT_EN
    ,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] illegal_cnt
`endif
);

    localparam int EW = 5 + 2 * N;

    logic [1:0]    count;
    logic [EW-1:0] ent0;
    logic [EW-1:0] ent1;
    logic [EW-1:0] in_ent;
    logic          push;
    logic          pop;

    // Returns {op[3:0], illegal}; anything not recognised decodes as op 0000 flagged illegal.
    function automatic logic [4:0] decode(input logic [1:0] aluop, input logic [5:0] funct);
        logic [4:0] r;
        r = {4'b0000, 1'b1};
        case (aluop)
            2'b00: r = {4'b0010, 1'b0};
            2'b01: r = {4'b0110, 1'b0};
            2'b10: begin
                case (funct)
                    6'b100000: r = {4'b0010, 1'b0};
                    6'b100010: r = {4'b0110, 1'b0};
                    6'b100100: r = {4'b0000, 1'b0};
                    6'b100101: r = {4'b0001, 1'b0};
                    6'b100111: r = {4'b1100, 1'b0};
                    6'b101010: r = {4'b0111, 1'b0};
                    default:   r = {4'b0000, 1'b1};
                endcase
            end
            default: r = {4'b0000, 1'b1};
        endcase
        return r;
    endfunction

    assign in_ent    = {decode(in_aluop, in_funct), in_a, in_b};
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign {out_op, out_illegal, out_a, out_b} = ent0;

    // ent0 is always the head; it is only overwritten when a new head arrives, so out_* hold while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            ent0  <= '0;
            ent1  <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) ent0 <= in_ent;
                    else               ent1 <= in_ent;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) ent0 <= ent1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    ent0 <= in_ent;
                end
                default: ;
            endcase
        end
    end

`ifdef ISSUE_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Counters see only pops that actually complete; a flush cancels that cycle's pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt   <= '0;
            illegal_cnt <= '0;
        end else if (pop && !flush) begin
            issue_cnt <= sat_inc(issue_cnt);
            if (out_illegal) illegal_cnt <= sat_inc(illegal_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage; counter checks run when ISSUE_CNT_EN is defined.
module tb_alu_issue_stage;

    localparam int N  = 32;
    localparam int CW = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_aluop;
    logic [5:0]   in_funct;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_op;
    logic [N-1:0] out_a;
    logic [N-1:0] out_b;
    logic         out_illegal;
`ifdef ISSUE_CNT_EN
    logic [CW-1:0] issue_cnt;
    logic [CW-1:0] illegal_cnt;
`endif

    int checks = 0;
    int errors = 0;

    alu_issue_stage #(.N(N), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_aluop    (in_aluop),
        .in_funct    (in_funct),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_illegal (out_illegal)
`ifdef ISSUE_CNT_EN
        ,
        .issue_cnt   (issue_cnt),
        .illegal_cnt (illegal_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] aluop, input logic [5:0] funct,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_aluop = aluop;
        in_funct = funct;
        in_a     = a;
        in_b     = b;
    endtask

    logic [1:0] sw_aluop [10];
    logic [5:0] sw_funct [10];
    logic [3:0] sw_op    [10];
    logic       sw_ill   [10];

    initial begin
        sw_aluop = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11};
        sw_funct = '{6'b000000, 6'b000000, 6'b100000, 6'b100010, 6'b100100,
                     6'b100101, 6'b100111, 6'b101010, 6'b000000, 6'b100000};
        sw_op    = '{4'b0010, 4'b0110, 4'b0010, 4'b0110, 4'b0000,
                     4'b0001, 4'b1100, 4'b0111, 4'b0000, 4'b0000};
        sw_ill   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_aluop = 2'b00; in_funct = 6'b0; in_a = '0; in_b = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_op", 32'(out_op), 32'd0);
        chk("rst_out_a", out_a, 32'd0);
        chk("rst_out_b", out_b, 32'd0);
        chk("rst_out_illegal", 32'(out_illegal), 32'd0);
`ifdef ISSUE_CNT_EN
        chk("rst_issue_cnt", 32'(issue_cnt), 32'd0);
        chk("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
`endif

        // single push, visible one cycle later
        drive(2'b10, 6'b100100, 32'hF0F0, 32'h0FF0);
        step();
        in_valid = 1'b0;
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_op", 32'(out_op), 32'b0000);
        chk("t1_a", out_a, 32'hF0F0);
        chk("t1_b", out_b, 32'h0FF0);
        chk("t1_illegal", 32'(out_illegal), 32'd0);
        out_ready = 1'b1;
        step();
        chk("t1_drained", 32'(out_valid), 32'd0);

        // decode sweep, one op per cycle
        for (int i = 0; i < 10; i++) begin
            drive(sw_aluop[i], sw_funct[i], 32'(i + 1), 32'(i + 50));
            step();
            chk($sformatf("dec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("dec%0d_op", i), 32'(out_op), 32'(sw_op[i]));
            chk($sformatf("dec%0d_ill", i), 32'(out_illegal), 32'(sw_ill[i]));
            chk($sformatf("dec%0d_a", i), out_a, 32'(i + 1));
        end
        in_valid = 1'b0;
        step();
        chk("dec_drained", 32'(out_valid), 32'd0);

        // backpressure: A, B fill, C held upstream
        out_ready = 1'b0;
        drive(2'b00, 6'b0, 32'hA, 32'h1);
        step();
        chk("bp_ready_c1", 32'(in_ready), 32'd1);
        drive(2'b00, 6'b0, 32'hB, 32'h2);
        step();
        chk("bp_ready_full", 32'(in_ready), 32'd0);
        drive(2'b00, 6'b0, 32'hC, 32'h3);
        step();
        chk("bp_ready_held", 32'(in_ready), 32'd0);
        chk("bp_head_A_held", out_a, 32'hA);
        step();
        chk("bp_head_A_stable", out_a, 32'hA);
        out_ready = 1'b1;
        step();
        chk("bp_head_B", out_a, 32'hB);
        chk("bp_ready_after_pop", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_head_C", out_a, 32'hC);
        chk("bp_head_C_b", out_b, 32'h3);
        step();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // streaming at one op per cycle
        for (int i = 0; i < 16; i++) begin
            drive(2'b01, 6'b0, 32'(i + 100), 32'(i));
            step();
            chk($sformatf("st%0d_ready", i), 32'(in_ready), 32'd1);
            chk($sformatf("st%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("st%0d_a", i), out_a, 32'(i + 100));
        end
        in_valid = 1'b0;
        step();
        chk("st_drained", 32'(out_valid), 32'd0);

        // flush at full with an input pending
        out_ready = 1'b0;
        drive(2'b00, 6'b0, 32'h11, 32'h0);
        step();
        drive(2'b00, 6'b0, 32'h22, 32'h0);
        step();
        drive(2'b00, 6'b0, 32'h33, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        drive(2'b00, 6'b0, 32'h44, 32'h0);
        step();
        in_valid = 1'b0;
        chk("fl_next_head", out_a, 32'h44);
        step();
        chk("fl_drained", 32'(out_valid), 32'd0);

        // asynchronous reset while holding an entry
        out_ready = 1'b0;
        drive(2'b00, 6'b0, 32'h55, 32'h0);
        step();
        in_valid = 1'b0;
        chk("ar_before", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("ar_valid_async", 32'(out_valid), 32'd0);
        chk("ar_ready_async", 32'(in_ready), 32'd1);
        step();
        rst = 1'b0;
        step();
        chk("ar_still_empty", 32'(out_valid), 32'd0);

`ifdef ISSUE_CNT_EN
        // 5 legal + 2 illegal pops
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) drive(2'b00, 6'b0, 32'(i), 32'(i));
            else       drive(2'b11, 6'b0, 32'(i), 32'(i));
            step();
        end
        in_valid = 1'b0;
        step();
        chk("cnt_issue7", 32'(issue_cnt), 32'd7);
        chk("cnt_illegal2", 32'(illegal_cnt), 32'd2);

        drive(2'b11, 6'b0, 32'h66, 32'h0);
        step();
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("cnt_flush_issue", 32'(issue_cnt), 32'd7);
        chk("cnt_flush_illegal", 32'(illegal_cnt), 32'd2);
        chk("cnt_flush_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < 10; i++) begin
            drive(2'b00, 6'b0, 32'(i), 32'(i));
            step();
        end
        in_valid = 1'b0;
        step();
        chk("cnt_issue_sat", 32'(issue_cnt), 32'hF);
        chk("cnt_illegal_keep", 32'(illegal_cnt), 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
